// File: rtl/vscale_wb_lane_serializer_xvec.sv
// ---------------------------------------------------------------------------
// vscale_wb_lane_serializer_xvec
//
// Writeback-side lane serializer for the xvec unit. Accepts one full-width
// vector result and drains it into the lane-addressed vector register file
// write port, one enabled lane per cycle, lowest lane first. The writeback
// stage is held off (wb_ready low) while a result is being drained.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   wb_valid      a result is offered this cycle
//   wb_ready      block can accept a result this cycle
//   wb_vector     1 = vector result, 0 = scalar result (lane 0 only)
//   wb_lane_mask  per-lane write enables (vector results only)
//   wb_reg_to_wr  destination register
//   wb_data       result; lane i at bits [i*XPR_LEN +: XPR_LEN]
//   wr_en         register file write strobe
//   wr_addr       write register
//   wr_lane       write lane index
//   wr_data       write data
//   wb_done       one-cycle pulse when a result has been fully retired
// ---------------------------------------------------------------------------
module vscale_wb_lane_serializer_xvec #(
  parameter int VEC_LEN        = 4,
  parameter int XPR_LEN        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LANE_IDX_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_valid,
  output logic                        wb_ready,
  input  logic                        wb_vector,
  input  logic [VEC_LEN-1:0]          wb_lane_mask,
  input  logic [REG_ADDR_WIDTH-1:0]   wb_reg_to_wr,
  input  logic [VEC_LEN*XPR_LEN-1:0]  wb_data,
  output logic                        wr_en,
  output logic [REG_ADDR_WIDTH-1:0]   wr_addr,
  output logic [LANE_IDX_WIDTH-1:0]   wr_lane,
  output logic [XPR_LEN-1:0]          wr_data,
  output logic                        wb_done
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                       state;
  logic [VEC_LEN-1:0]           pend_mask;
  logic [REG_ADDR_WIDTH-1:0]    addr_q;
  logic [VEC_LEN*XPR_LEN-1:0]   data_q;

  logic [VEC_LEN-1:0]           emask;
  logic [VEC_LEN-1:0]           next_mask;

  // Index of the lowest set bit; 0 for an empty mask (value unused then).
  function automatic logic [LANE_IDX_WIDTH-1:0] low_idx(input logic [VEC_LEN-1:0] m);
    logic [LANE_IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = VEC_LEN - 1; i >= 0; i--) begin
      if (m[i]) idx = LANE_IDX_WIDTH'(i);
    end
    return idx;
  endfunction

  function automatic logic [VEC_LEN-1:0] clear_low(input logic [VEC_LEN-1:0] m);
    return m & (m - VEC_LEN'(1));
  endfunction

  function automatic logic [XPR_LEN-1:0] lane_word(input logic [VEC_LEN*XPR_LEN-1:0] d,
                                                   input logic [LANE_IDX_WIDTH-1:0] idx);
    return d[int'(idx)*XPR_LEN +: XPR_LEN];
  endfunction

  // NOTE: every variable assigned in always_comb gets an unconditional
  // default first, so no path leaves it holding a value (no latch).
  always_comb begin
    emask = wb_vector ? wb_lane_mask : VEC_LEN'(1);
    if (wb_reg_to_wr == '0) emask = '0;  // writes to x0 are dropped
  end

  assign next_mask = clear_low(pend_mask);

  // Not registered on purpose: the port must read low while reset is held.
  assign wb_ready = (state == IDLE) && !reset;

  // Outputs are registered and always describe the lane at the bottom of
  // pend_mask, so they are computed one edge ahead from the mask that will
  // be current in the next cycle (emask on accept, next_mask while draining).
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide data_q is reset as well so wr_data is deterministic
      // out of reset; it is a flop array, not a memory macro.
      state     <= IDLE;
      pend_mask <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_lane   <= '0;
      wr_data   <= '0;
      wb_done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wr_en   <= 1'b0;
          wb_done <= 1'b0;
          if (wb_valid) begin
            state     <= DRAIN;
            pend_mask <= emask;
            addr_q    <= wb_reg_to_wr;
            data_q    <= wb_data;
            wr_en     <= |emask;
            wr_addr   <= wb_reg_to_wr;
            wr_lane   <= low_idx(emask);
            wr_data   <= lane_word(wb_data, low_idx(emask));
            // Empty mask still retires, in one cycle with no write.
            wb_done   <= (clear_low(emask) == '0);
          end
        end
        DRAIN: begin
          pend_mask <= next_mask;
          if (next_mask == '0) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            wb_done <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= addr_q;
            wr_lane <= low_idx(next_mask);
            wr_data <= lane_word(data_q, low_idx(next_mask));
            wb_done <= (clear_low(next_mask) == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
